// File: rtl/pal_padding_ctrl_if.sv
// Sync and clock-gate signals between the VDG sync taps and the PAL padding sequencer.
interface pal_padding_ctrl_if;
   logic ENABLE;
   logic HS_n;
   logic FS_n;
   logic VCLK_EN;
   logic HS_OUT_n;
   logic PADDING;

   // Stimulus side: drives VDG syncs and enable, observes the gated outputs.
   modport master (
      output ENABLE,
      output HS_n,
      output FS_n,
      input  VCLK_EN,
      input  HS_OUT_n,
      input  PADDING
   );

   // Sequencer side.
   modport slave (
      input  ENABLE,
      input  HS_n,
      input  FS_n,
      output VCLK_EN,
      output HS_OUT_n,
      output PADDING
   );
endinterface

// File: rtl/pal_padding_ctrl.sv
// PAL line padding sequencer for the Dragon VDG: freezes the VDG clock and emits
// synthetic blank lines in two windows per field (after FS fall and after FS rise).
module pal_padding_ctrl #(
   parameter int unsigned LINE_LEN = 64,
   parameter int unsigned HS_LEN   = 5,
   parameter int unsigned PAD_A    = 25,
   parameter int unsigned PAD_B    = 25,
   parameter int unsigned SKIP_B   = 0
) (
   input logic              A,
   input logic              nRESET,
   pal_padding_ctrl_if.slave bus
);

   localparam int unsigned DOT_W  = 10;
   localparam int unsigned LINE_W = 6;
   localparam int unsigned SKIP_W = 6;

   localparam logic [DOT_W-1:0]  DOT_LAST = DOT_W'(LINE_LEN - 1);
   localparam logic [DOT_W-1:0]  HS_END   = DOT_W'(HS_LEN);
   localparam logic [LINE_W-1:0] LAST_A   = (PAD_A == 0) ? '0 : LINE_W'(PAD_A - 1);
   localparam logic [LINE_W-1:0] LAST_B   = (PAD_B == 0) ? '0 : LINE_W'(PAD_B - 1);
   localparam logic [SKIP_W-1:0] SKIP_INI = SKIP_W'(SKIP_B);

   // Reject parameter sets the counters or the HS pulse cannot represent.
   if (HS_LEN >= LINE_LEN || HS_LEN < 1) begin : g_bad_hs_len
      $error("pal_padding_ctrl: HS_LEN must be in 1..LINE_LEN-1");
   end
   if (LINE_LEN < 2 || LINE_LEN > 1023) begin : g_bad_line_len
      $error("pal_padding_ctrl: LINE_LEN must be in 2..1023");
   end
   if (PAD_A > 63 || PAD_B > 63 || SKIP_B > 63) begin : g_bad_counts
      $error("pal_padding_ctrl: PAD_A, PAD_B, SKIP_B must be in 0..63");
   end

   typedef enum logic [2:0] {
      S_RUN   = 3'd0,
      S_ARM_A = 3'd1,
      S_ARM_B = 3'd2,
      S_PAD_A = 3'd3,
      S_PAD_B = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [DOT_W-1:0]    dot_q, dot_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [SKIP_W-1:0]   skip_q, skip_d;
   logic                hs_d_q, fs_d_q;
   logic                vclk_en_q, vclk_en_d;
   logic                hs_out_n_q, hs_out_n_d;
   logic                padding_q, padding_d;

   logic                hs_fall_c, fs_fall_c, fs_rise_c;
   logic                pad_next_c;
   logic [LINE_W-1:0]   line_last_c;

   assign hs_fall_c = hs_d_q & ~bus.HS_n;
   assign fs_fall_c = fs_d_q & ~bus.FS_n;
   assign fs_rise_c = ~fs_d_q & bus.FS_n;

   // State register, counters, sync history and registered outputs.
   always_ff @(posedge A or negedge nRESET) begin
      if (!nRESET) begin
         state_q    <= S_RUN;
         dot_q      <= '0;
         line_q     <= '0;
         skip_q     <= '0;
         hs_d_q     <= 1'b1;
         fs_d_q     <= 1'b1;
         vclk_en_q  <= 1'b1;
         hs_out_n_q <= 1'b1;
         padding_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         dot_q      <= dot_d;
         line_q     <= line_d;
         skip_q     <= skip_d;
         hs_d_q     <= bus.HS_n;
         fs_d_q     <= bus.FS_n;
         vclk_en_q  <= vclk_en_d;
         hs_out_n_q <= hs_out_n_d;
         padding_q  <= padding_d;
      end
   end

   // Next-state, counter update and output decode from the next state.
   always_comb begin
      state_d     = state_q;
      dot_d       = dot_q;
      line_d      = line_q;
      skip_d      = skip_q;
      line_last_c = (state_q == S_PAD_A) ? LAST_A : LAST_B;

      if (!bus.ENABLE) begin
         state_d = S_RUN;
         dot_d   = '0;
         line_d  = '0;
         skip_d  = '0;
      end else begin
         case (state_q)
            S_RUN: begin
               // An HS fall on the same edge as the FS edge is not consumed.
               if (fs_fall_c) begin
                  state_d = S_ARM_A;
               end else if (fs_rise_c) begin
                  state_d = S_ARM_B;
                  skip_d  = SKIP_INI;
               end
            end
            S_ARM_A: begin
               if (hs_fall_c) begin
                  state_d = (PAD_A == 0) ? S_RUN : S_PAD_A;
                  dot_d   = '0;
                  line_d  = '0;
               end
            end
            S_ARM_B: begin
               // A new field start overrides a pending bottom window.
               if (fs_fall_c) begin
                  state_d = S_ARM_A;
               end else if (hs_fall_c) begin
                  if (skip_q == '0) begin
                     state_d = (PAD_B == 0) ? S_RUN : S_PAD_B;
                     dot_d   = '0;
                     line_d  = '0;
                  end else begin
                     skip_d = skip_q - SKIP_W'(1);
                  end
               end
            end
            S_PAD_A, S_PAD_B: begin
               // VDG is frozen here, so its sync edges are ignored.
               if (dot_q == DOT_LAST) begin
                  dot_d = '0;
                  if (line_q == line_last_c) begin
                     state_d = S_RUN;
                     line_d  = '0;
                  end else begin
                     line_d = line_q + LINE_W'(1);
                  end
               end else begin
                  dot_d = dot_q + DOT_W'(1);
               end
            end
            default: begin
               state_d = S_RUN;
               dot_d   = '0;
               line_d  = '0;
               skip_d  = '0;
            end
         endcase
      end

      pad_next_c = (state_d == S_PAD_A) || (state_d == S_PAD_B);
      vclk_en_d  = ~pad_next_c;
      padding_d  = pad_next_c;
      hs_out_n_d = pad_next_c ? (dot_d >= HS_END) : bus.HS_n;
   end

   assign bus.VCLK_EN  = vclk_en_q;
   assign bus.HS_OUT_n = hs_out_n_q;
   assign bus.PADDING  = padding_q;

endmodule
